// File: rtl/credit_pkg.sv
// ============================================================================
// Module : credit_pkg
// Brief  : Shared types and helpers for the credit-based link transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package credit_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        QUIESCE = 2'd2
    } credit_state_e;

    // Width needed to hold every value from 0 up to and including credits.
    function automatic int cnt_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/credit_counter.sv
// ============================================================================
// Module : credit_counter
// Brief  : Saturating up/down counter, reset/loaded to MAX; load wins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module credit_counter
    import credit_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_w(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    output logic [W-1:0] count,
    output logic         ovf
);

    localparam logic [W-1:0] C_MAX = W'(MAX);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= C_MAX;
        end else if (load) begin
            r_count <= C_MAX;
        end else if (inc && !dec && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A lone increment at the ceiling is a protocol violation by the far end.
    assign ovf   = inc && !dec && !load && (r_count == C_MAX);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/credit_tx.sv
// ============================================================================
// Module : credit_tx
// Brief  : Credit-based transmitter onto a valid-only remote FIFO link,
//          including the remote flush and credit resynchronisation sequence.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module credit_tx
    import credit_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int CREDITS = 4,
    parameter  int RET_LAT = 2,
    localparam int CNT_W   = cnt_w(CREDITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              tx_flush,
    input  logic              credit_ret,
    input  logic              flush_req,
    output logic [CNT_W-1:0]  credits,
    output logic              idle,
    output logic              err_ovf
);

    localparam int             C_QW      = (RET_LAT > 1) ? $clog2(RET_LAT) : 1;
    localparam logic [C_QW-1:0] C_QLOAD  = (RET_LAT > 0) ? C_QW'(RET_LAT - 1) : '0;
    localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(CREDITS);

    credit_state_e     r_state;
    logic [C_QW-1:0]   r_qcnt;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_tx_flush;
    logic              r_err_ovf;

    logic [CNT_W-1:0]  w_count;
    logic              w_ovf;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_inc;
    logic              w_load;

    assign w_in_ready = (r_state == RUN) && (w_count != '0);
    assign w_accept   = in_valid && w_in_ready;
    // Returns arriving outside RUN belong to entries the flush already discarded.
    assign w_inc      = credit_ret && (r_state == RUN);
    assign w_load     = (r_state == FLUSH);

    credit_counter #(
        .MAX (CREDITS),
        .W   (CNT_W)
    ) u_credit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc),
        .dec   (w_accept),
        .load  (w_load),
        .count (w_count),
        .ovf   (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_qcnt     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_flush <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            r_tx_valid <= w_accept;
            r_tx_flush <= (r_state == FLUSH);
            r_err_ovf  <= r_err_ovf | w_ovf;
            if (w_accept) begin
                r_tx_data <= in_data;
            end

            // The flush strobe lags FLUSH by a cycle so a beat accepted on the
            // request cycle reaches the link before the remote FIFO is cleared.
            case (r_state)
                RUN: begin
                    if (flush_req) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (RET_LAT > 0) begin
                        r_state <= QUIESCE;
                        r_qcnt  <= C_QLOAD;
                    end else begin
                        r_state <= RUN;
                    end
                end
                QUIESCE: begin
                    if (r_qcnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_qcnt <= r_qcnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_flush = r_tx_flush;
    assign credits  = w_count;
    assign idle     = (w_count == C_FULL) && (r_state == RUN);
    assign err_ovf  = r_err_ovf;

endmodule

`default_nettype wire
